// File: rtl/sdram_wr_buf_pkg.sv
// Shared constants and FSM encodings for the SDRAM write-side staging buffer.
package sdram_wr_buf_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_BURST_LEN = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_BURST = 2'd2
    } state_t;

endpackage

// File: rtl/sdram_wr_buf_ram.sv
// Simple dual-port RAM: synchronous write, registered read with enable.
module sdram_wr_buf_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              sysclk_100M,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge sysclk_100M) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Output register holds its value between reads; only it is reset, not the array.
    always_ff @(posedge sysclk_100M) begin
        if (rst)
            rd_data_reg <= '0;
        else if (rd_en)
            rd_data_reg <= mem[rd_addr];
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/sdram_wr_buf.sv
// Byte staging buffer that raises write_trig once a full SDRAM burst is queued.
module sdram_wr_buf
    import sdram_wr_buf_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic                       sysclk_100M,
    input  logic                       rst,
    input  logic                       in_vld,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_rdy,
    output logic                       write_trig,
    input  logic                       data_vld,
    output logic [DATA_W-1:0]          w_dq,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    output logic                       udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(BURST_LEN) + 1;

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          ovf_reg;
    logic          udf_reg;
    state_t        state_reg;
    logic [PW-1:0] pop_cnt_reg;
    logic          write_trig_reg;

    logic          push_ok;
    logic          pop_ok;

    assign in_rdy  = (count_reg != CW'(DEPTH));
    assign push_ok = in_vld && in_rdy && !rst;
    assign pop_ok  = data_vld && (count_reg != '0) && !rst;

    sdram_wr_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .sysclk_100M (sysclk_100M),
        .rst         (rst),
        .wr_en       (push_ok),
        .wr_addr     (wr_ptr_reg),
        .wr_data     (in_data),
        .rd_en       (pop_ok),
        .rd_addr     (rd_ptr_reg),
        .rd_data     (w_dq)
    );

    always_ff @(posedge sysclk_100M) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            udf_reg    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (in_vld && !in_rdy)
                ovf_reg <= 1'b1;
            if (data_vld && (count_reg == '0))
                udf_reg <= 1'b1;
        end
    end

    // Burst FSM; IDLE always lasts at least one cycle so write_trig drops between bursts.
    always_ff @(posedge sysclk_100M) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            pop_cnt_reg    <= '0;
            write_trig_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    pop_cnt_reg <= '0;
                    if (count_reg >= CW'(BURST_LEN)) begin
                        state_reg      <= ST_ARMED;
                        write_trig_reg <= 1'b1;
                    end else begin
                        write_trig_reg <= 1'b0;
                    end
                end
                ST_ARMED, ST_BURST: begin
                    if (pop_ok) begin
                        write_trig_reg <= 1'b0;
                        if (pop_cnt_reg + PW'(1) == PW'(BURST_LEN)) begin
                            state_reg   <= ST_IDLE;
                            pop_cnt_reg <= '0;
                        end else begin
                            state_reg   <= ST_BURST;
                            pop_cnt_reg <= pop_cnt_reg + PW'(1);
                        end
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    pop_cnt_reg    <= '0;
                    write_trig_reg <= 1'b0;
                end
            endcase
        end
    end

    assign write_trig = write_trig_reg;
    assign count      = count_reg;
    assign ovf        = ovf_reg;
    assign udf        = udf_reg;

endmodule

// File: tb/tb_sdram_wr_buf.sv
// Randomised and directed checks of sdram_wr_buf against a queue-based reference model.
module tb_sdram_wr_buf;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int BL    = 4;

    logic          sysclk_100M = 1'b0;
    logic          rst         = 1'b1;
    logic          in_vld      = 1'b0;
    logic [DW-1:0] in_data     = '0;
    logic          data_vld    = 1'b0;
    logic          in_rdy;
    logic          write_trig;
    logic [DW-1:0] w_dq;
    logic [4:0]    count;
    logic          ovf;
    logic          udf;

    int n_checks = 0;
    int n_fail   = 0;

    sdram_wr_buf #(.DATA_W(DW), .DEPTH(DEPTH), .BURST_LEN(BL)) dut (
        .sysclk_100M (sysclk_100M),
        .rst         (rst),
        .in_vld      (in_vld),
        .in_data     (in_data),
        .in_rdy      (in_rdy),
        .write_trig  (write_trig),
        .data_vld    (data_vld),
        .w_dq        (w_dq),
        .count       (count),
        .ovf         (ovf),
        .udf         (udf)
    );

    always #5 sysclk_100M = ~sysclk_100M;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: buffer is a queue; burst handshake is a phase (0 idle, 1 waiting, 2 bursting).
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_wdq;
    bit            m_ovf;
    bit            m_udf;
    int            m_phase;
    int            m_pops;
    bit            m_valid = 1'b0;

    always @(posedge sysclk_100M) begin
        int  pre;
        bit  popped;
        if (rst) begin
            mq.delete();
            m_wdq   = '0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_phase = 0;
            m_pops  = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            pre    = mq.size();
            popped = 1'b0;
            if (data_vld) begin
                if (pre > 0) begin
                    m_wdq  = mq.pop_front();
                    popped = 1'b1;
                end else begin
                    m_udf = 1'b1;
                end
            end
            if (in_vld) begin
                if (pre < DEPTH) mq.push_back(in_data);
                else             m_ovf = 1'b1;
            end
            if (m_phase == 0) begin
                m_pops = 0;
                if (pre >= BL) m_phase = 1;
            end else if (popped) begin
                m_pops++;
                if (m_pops == BL) begin
                    m_phase = 0;
                    m_pops  = 0;
                end else begin
                    m_phase = 2;
                end
            end
        end
    end

    always @(negedge sysclk_100M) begin
        if (m_valid && !rst) begin
            chk("count",      32'(count),      32'(mq.size()));
            chk("in_rdy",     32'(in_rdy),     32'(mq.size() != DEPTH));
            chk("write_trig", 32'(write_trig), 32'(m_phase == 1));
            chk("w_dq",       32'(w_dq),       32'(m_wdq));
            chk("ovf",        32'(ovf),        32'(m_ovf));
            chk("udf",        32'(udf),        32'(m_udf));
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic p);
        in_vld   = v;
        in_data  = d;
        data_vld = p;
        @(posedge sysclk_100M);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 8'h77, 1'b1);
        rst = 1'b0;
        in_vld   = 1'b0;
        data_vld = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count),      32'd0);
        chk({tag, "_rdy"},   32'(in_rdy),     32'd1);
        chk({tag, "_trig"},  32'(write_trig), 32'd0);
        chk({tag, "_wdq"},   32'(w_dq),       32'd0);
        chk({tag, "_ovf"},   32'(ovf),        32'd0);
        chk({tag, "_udf"},   32'(udf),        32'd0);
    endtask

    initial begin
        logic [DW-1:0] pat [4];
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;

        step(1'b0, '0, 1'b0);
        do_reset();
        chk_reset_state("rst0");

        // Single burst of four bytes
        for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b0);
        chk("b1_count", 32'(count), 32'd4);
        chk("b1_trig_lo", 32'(write_trig), 32'd0);
        step(1'b0, '0, 1'b0);
        chk("b1_trig_hi", 32'(write_trig), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1);
            chk($sformatf("b1_wdq%0d", i), 32'(w_dq), 32'(pat[i]));
            chk($sformatf("b1_trig_burst%0d", i), 32'(write_trig), 32'd0);
        end
        step(1'b0, '0, 1'b0);
        chk("b1_trig_idle", 32'(write_trig), 32'd0);

        // Underflow pop with simultaneous push
        step(1'b1, 8'h5A, 1'b1);
        chk("udf_flag", 32'(udf), 32'd1);
        chk("udf_count", 32'(count), 32'd1);
        chk("udf_wdq_hold", 32'(w_dq), 32'h44);
        step(1'b0, '0, 1'b1);
        chk("udf_pop", 32'(w_dq), 32'h5A);

        // Overflow: 17 pushes, then push-while-full with pop
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b0);
            if (i == 15) begin
                chk("ovf_rdy_lo", 32'(in_rdy), 32'd0);
                chk("ovf_pre", 32'(ovf), 32'd0);
            end
        end
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        step(1'b1, 8'hAA, 1'b1);
        chk("ovf_aa_pop", 32'(w_dq), 32'h80);
        chk("ovf_aa_count", 32'(count), 32'd15);
        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1);
        chk("ovf_last", 32'(w_dq), 32'h8F);
        chk("ovf_empty", 32'(count), 32'd0);

        // Two back-to-back bursts from eight held bytes
        do_reset();
        chk_reset_state("rst1");
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b0, '0, 1'b0);
        chk("b2_trig1", 32'(write_trig), 32'd1);
        for (int i = 1; i <= 4; i++) step(1'b0, '0, 1'b1);
        chk("b2_gap", 32'(write_trig), 32'd0);
        step(1'b0, '0, 1'b0);
        chk("b2_trig2", 32'(write_trig), 32'd1);
        for (int i = 5; i <= 8; i++) begin
            step(1'b0, '0, 1'b1);
            chk($sformatf("b2_wdq%0d", i), 32'(w_dq), 32'(i));
        end

        // Reset in the middle of a burst
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        do_reset();
        chk_reset_state("rst_mid");

        // Interleaved traffic wrapping both pointers
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'hC0 + i), 1'(i >= 3));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        chk("wrap_last", 32'(w_dq), 32'hD3);
        chk("wrap_empty", 32'(count), 32'd0);

        // Random traffic, alternating fill-heavy and drain-heavy phases
        for (int i = 0; i < 1200; i++) begin
            int pv;
            int pp;
            pv = ((i / 150) % 2 == 0) ? 85 : 35;
            pp = ((i / 150) % 2 == 0) ? 30 : 80;
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 99) < pv), 8'($urandom), 1'($urandom_range(0, 99) < pp));
            end
        end

        step(1'b0, '0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
